// File: rtl/daq_evt_arbiter.sv
// Round-robin event arbiter: moves whole events from three FWFT source FIFOs
// into the USB IN-channel FIFO and generates packet-end strobes.
module daq_evt_arbiter #(
  parameter int PKT_WORDS     = 256,
  parameter bit PKTEND_ON_EOE = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        src0_empty_i,
  input  logic [31:0] src0_data_i,
  input  logic        src0_eoe_i,
  output logic        src0_re_o,
  input  logic        src1_empty_i,
  input  logic [31:0] src1_data_i,
  input  logic        src1_eoe_i,
  output logic        src1_re_o,
  input  logic        src2_empty_i,
  input  logic [31:0] src2_data_i,
  input  logic        src2_eoe_i,
  output logic        src2_re_o,
  input  logic [2:0]  en_i,
  input  logic        out_afull_i,
  output logic [31:0] out_data_o,
  output logic        out_we_o,
  output logic        out_pktend_o,
  output logic        busy_o,
  output logic [1:0]  grant_o
);

  localparam int CW = $clog2(PKT_WORDS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t         state;
  logic [1:0]     rr_ptr;
  logic [1:0]     grant;
  logic [CW-1:0]  pkt_cnt;
  logic [2:0]     empty;
  logic [2:0]     eligible;
  logic           hit;
  logic [1:0]     sel;
  logic [1:0]     cand;
  logic [31:0]    head_data;
  logic           head_eoe;
  logic           head_empty;
  logic           pop;
  logic           pkt_end_now;

  // rr_ptr holds the first source to search, i.e. (last grant + 1) mod 3.
  function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign empty    = {src2_empty_i, src1_empty_i, src0_empty_i};
  assign eligible = en_i & ~empty;

  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      cand = rr_next(rr_ptr, 2'(k));
      if (!hit && eligible[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  always_comb begin
    head_data  = src0_data_i;
    head_eoe   = src0_eoe_i;
    head_empty = src0_empty_i;
    case (grant)
      2'd1: begin
        head_data  = src1_data_i;
        head_eoe   = src1_eoe_i;
        head_empty = src1_empty_i;
      end
      2'd2: begin
        head_data  = src2_data_i;
        head_eoe   = src2_eoe_i;
        head_empty = src2_empty_i;
      end
      default: ;
    endcase
  end

  assign pop         = (state == XFER) && !rst_i && !head_empty && !out_afull_i;
  assign pkt_end_now = (pkt_cnt == CNT_LAST) || (head_eoe && PKTEND_ON_EOE);

  assign src0_re_o = pop && (grant == 2'd0);
  assign src1_re_o = pop && (grant == 2'd1);
  assign src2_re_o = pop && (grant == 2'd2);
  assign busy_o    = (state != IDLE);
  assign grant_o   = grant;

  // The packet decision is taken at pop time and registered with the word,
  // so the counter tracks words committed to the output stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      pkt_cnt      <= '0;
      out_we_o     <= 1'b0;
      out_pktend_o <= 1'b0;
      out_data_o   <= '0;
    end else begin
      out_we_o     <= pop;
      out_pktend_o <= pop && pkt_end_now;
      if (pop) begin
        out_data_o <= head_data;
        pkt_cnt    <= pkt_end_now ? '0 : pkt_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (hit) begin
            grant <= sel;
            state <= XFER;
          end
        end
        XFER: begin
          if (pop && head_eoe) state <= DRAIN;
        end
        DRAIN: begin
          state  <= IDLE;
          rr_ptr <= rr_next(grant, 2'd1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
